// File: rtl/param_pipe_register_if.sv
// Handshake bus for param_pipe_register: upstream valid/ready input side,
// downstream valid/ready output side, plus flush and occupancy count.
interface param_pipe_register_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/param_pipe_register.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing,
// synchronous flush and asynchronous active-high reset.
module param_pipe_register #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                 clk,
  input logic                 reset,
  param_pipe_register_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]             v_q, v_d, mv;
  logic [DEPTH-1:0][WIDTH-1:0]  d_q, d_d;
  logic                         acc0;
  logic                         in_xfer;
  logic [CW-1:0]                cnt;

  // Ready ripples from the output side back to stage 0 so a stalled
  // stage only blocks its predecessor if it cannot move itself.
  always_comb begin : g_move
    logic acc;
    acc = bus.out_ready;
    mv  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      mv[i] = v_q[i] & acc;
      acc   = ~v_q[i] | mv[i];
    end
    acc0 = acc;
  end

  assign bus.in_ready = acc0 & ~bus.flush;
  assign in_xfer      = bus.in_valid & bus.in_ready;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic             ld;
      logic [WIDTH-1:0] src;
      if (g == 0) begin : g_head
        assign ld  = in_xfer;
        assign src = bus.in_data;
      end else begin : g_body
        assign ld  = mv[g-1];
        assign src = d_q[g-1];
      end
      // Refill wins over draining; a drained stage keeps its stale data.
      assign v_d[g] = bus.flush ? 1'b0      : ld ? 1'b1 : mv[g] ? 1'b0 : v_q[g];
      assign d_d[g] = bus.flush ? RESET_VAL : ld ? src  : d_q[g];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      d_q <= {DEPTH{RESET_VAL}};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + CW'(v_q[i]);
  end

  assign bus.out_valid = v_q[DEPTH-1] & ~bus.flush;
  assign bus.out_data  = d_q[DEPTH-1];
  assign bus.count     = cnt;
endmodule

// File: tb/tb_param_pipe_register.sv
// Bench for param_pipe_register: per-cycle vector table, scoreboard of
// accepted words against delivered words, occupancy model, random traffic.
module tb_param_pipe_register;
  localparam int W = 4;
  localparam int D = 3;
  localparam logic [W-1:0] RV = 4'b0101;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   mcnt = 0;
  logic [W-1:0] sb[$];

  param_pipe_register_if #(.WIDTH(W), .DEPTH(D)) bus ();

  param_pipe_register #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [3:0] id;
    logic       ordy;
    logic       fl;
    logic       e_ir;
    logic       e_ov;
    logic [3:0] e_od;
    logic [1:0] e_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [3:0] id, input logic ordy, input logic fl,
                     input logic e_ir, input logic e_ov, input logic [3:0] e_od,
                     input logic [1:0] e_cnt);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  // Called at posedge+1; drives one row, checks before the next edge.
  task automatic run_table(input string tag);
    foreach (tbl[k]) begin
      bus.in_valid  = tbl[k].iv;
      bus.in_data   = tbl[k].id;
      bus.out_ready = tbl[k].ordy;
      bus.flush     = tbl[k].fl;
      #3;
      chk($sformatf("%s[%0d].in_ready", tag, k), 32'(bus.in_ready), 32'(tbl[k].e_ir));
      chk($sformatf("%s[%0d].out_valid", tag, k), 32'(bus.out_valid), 32'(tbl[k].e_ov));
      chk($sformatf("%s[%0d].out_data", tag, k), 32'(bus.out_data), 32'(tbl[k].e_od));
      chk($sformatf("%s[%0d].count", tag, k), 32'(bus.count), 32'(tbl[k].e_cnt));
      @(posedge clk); #1;
    end
    tbl.delete();
  endtask

  // Scoreboard and occupancy model, sampled mid-cycle before the edge.
  initial forever begin
    @(negedge clk);
    if (reset !== 1'b1) begin
      chk("model.count", 32'(bus.count), 32'(mcnt));
      if (bus.flush) begin
        sb.delete();
        mcnt = 0;
      end else begin
        if (bus.in_valid && bus.in_ready) begin
          sb.push_back(bus.in_data);
          mcnt++;
        end
        if (bus.out_valid && bus.out_ready) begin
          chk("sb.nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) chk("sb.order", 32'(bus.out_data), 32'(sb.pop_front()));
          mcnt--;
        end
      end
    end
  end

  initial forever begin
    @(posedge reset);
    sb.delete();
    mcnt = 0;
  end

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #2;
    chk("reset.out_data", 32'(bus.out_data), 32'(RV));
    chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset.count", 32'(bus.count), 32'd0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Latency with an empty pipe and out_ready high.
    add(1, 4'b1010, 1, 0, 1, 0, 4'b0101, 0);
    add(1, 4'b1111, 1, 0, 1, 0, 4'b0101, 1);
    add(0, 4'b0000, 1, 0, 1, 0, 4'b0101, 2);
    add(0, 4'b0000, 1, 0, 1, 1, 4'b1010, 2);
    add(0, 4'b0000, 1, 0, 1, 1, 4'b1111, 1);
    add(0, 4'b0000, 1, 0, 1, 0, 4'b1111, 0);
    // Stall: fill to full, fourth word refused, then drain in order.
    add(1, 4'b1100, 0, 0, 1, 0, 4'b1111, 0);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b1111, 1);
    add(1, 4'b1001, 0, 0, 1, 0, 4'b1111, 2);
    add(1, 4'b0110, 0, 0, 0, 1, 4'b1100, 3);
    add(1, 4'b0110, 0, 0, 0, 1, 4'b1100, 3);
    add(0, 4'b0000, 1, 0, 1, 1, 4'b1100, 3);
    add(0, 4'b0000, 1, 0, 1, 1, 4'b0011, 2);
    add(0, 4'b0000, 1, 0, 1, 1, 4'b1001, 1);
    add(0, 4'b0000, 1, 0, 1, 0, 4'b1001, 0);
    // Fill, then full-rate streaming for five cycles.
    add(1, 4'b0001, 0, 0, 1, 0, 4'b1001, 0);
    add(1, 4'b0010, 0, 0, 1, 0, 4'b1001, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b1001, 2);
    add(1, 4'b0100, 1, 0, 1, 1, 4'b0001, 3);
    add(1, 4'b0101, 1, 0, 1, 1, 4'b0010, 3);
    add(1, 4'b0110, 1, 0, 1, 1, 4'b0011, 3);
    add(1, 4'b0111, 1, 0, 1, 1, 4'b0100, 3);
    add(1, 4'b1000, 1, 0, 1, 1, 4'b0101, 3);
    // Drain one, then flush with two words held and input offered.
    add(0, 4'b0000, 1, 0, 1, 1, 4'b0110, 3);
    add(1, 4'b1111, 1, 1, 0, 0, 4'b0111, 2);
    add(0, 4'b0000, 0, 0, 1, 0, 4'b0101, 0);
    // Refill to full with output stalled, ahead of a mid-cycle reset.
    add(1, 4'b0001, 0, 0, 1, 0, 4'b0101, 0);
    add(1, 4'b0010, 0, 0, 1, 0, 4'b0101, 1);
    add(1, 4'b0011, 0, 0, 1, 0, 4'b0101, 2);
    add(0, 4'b0000, 0, 0, 0, 1, 4'b0001, 3);
    run_table("vec");

    #2 reset = 1'b1;
    #1;
    chk("midrst.count", 32'(bus.count), 32'd0);
    chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.out_data", 32'(bus.out_data), 32'(RV));
    chk("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.in_data = 4'b0111;
    @(posedge clk); #1;
    reset = 1'b0;

    add(1, 4'b1110, 1, 0, 1, 0, 4'b0101, 0);
    add(0, 4'b0000, 1, 0, 1, 0, 4'b0101, 1);
    add(0, 4'b0000, 1, 0, 1, 0, 4'b0101, 1);
    add(0, 4'b0000, 1, 0, 1, 1, 4'b1110, 1);
    add(0, 4'b0000, 1, 0, 1, 0, 4'b1110, 0);
    run_table("post");

    // Random traffic with occasional flushes; scoreboard does the checking.
    for (int n = 0; n < 300; n++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 24) == 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (D + 2) begin
      @(posedge clk); #1;
    end
    #3;
    chk("end.sb_empty", 32'(sb.size()), 32'd0);
    chk("end.count", 32'(bus.count), 32'd0);
    chk("end.out_valid", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
